// File: rtl/and_seq_reducer_pkg.sv
// Shared types and elaboration helpers for the sequential AND reducer.
package and_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/and_chunk.sv
// Combinational W-bit AND chain; bit 0 seeds the chain.
module and_chunk #(
  parameter int W = 4
) (
  input  logic [0:W-1] i_x,
  output logic         o_y
);

  logic [0:W-1] w_chain;

  assign w_chain[0] = i_x[0];

  for (genvar g = 1; g < W; g++) begin : g_chain
    assign w_chain[g] = w_chain[g-1] & i_x[g];
  end

  assign o_y = w_chain[W-1];

endmodule

// File: rtl/and_seq_reducer.sv
// Multi-cycle AND reduction: consumes W operand bits per cycle, returns 1-bit result.
module and_seq_reducer
  import and_seq_pkg::*;
#(
  parameter int N          = 16,
  parameter int W          = 4,
  parameter int EARLY_EXIT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:N-1] in_x,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_y,
  output logic         out_early,
  output logic         busy
);

  localparam int CHUNKS = N / W;
  localparam int CW     = clog2(CHUNKS + 1);

  state_t         r_state;
  logic [0:N-1]   r_shreg;
  logic           r_acc;
  logic [CW-1:0]  r_cnt;
  logic           r_y;
  logic           r_early;

  logic           w_chunk;
  logic           w_acc_next;
  logic           w_last;
  logic           w_exit;

  and_chunk #(.W(W)) u_chunk (
    .i_x (r_shreg[0:W-1]),
    .o_y (w_chunk)
  );

  assign w_acc_next = r_acc & w_chunk;
  assign w_last     = (r_cnt == CW'(CHUNKS - 1));
  assign w_exit     = w_last || ((EARLY_EXIT != 0) && !w_acc_next);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_acc   <= 1'b1;
      r_cnt   <= '0;
      r_y     <= 1'b0;
      r_early <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_shreg <= in_x;
            r_acc   <= 1'b1;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          // Shift toward index 0 so the next chunk always sits at [0:W-1].
          r_acc   <= w_acc_next;
          r_shreg <= r_shreg << W;
          r_cnt   <= r_cnt + 1'b1;
          if (w_exit) begin
            r_y     <= w_acc_next;
            r_early <= !w_last;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign out_y     = r_y;
  assign out_early = r_early;

endmodule
